// File: rtl/alu_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Purpose  : Shared types and constants for the two-requester ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_OPCODE = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter_if
// Purpose  : Request/response bundle between requesters and the ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_req_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3
);
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic [OPCODE-1:0]  req0_op;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic [OPCODE-1:0]  req1_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_carry;
    logic               rsp_zero;
    logic               rsp_slt;
    logic               rsp_err;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_slt, rsp_err
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_slt, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/ALU.sv
`default_nettype none
// ============================================================================
// Module   : ALU
// Purpose  : Combinational ALU core: add/sub/and/or/xor/slt/not with status flags.
// Revision : 1.0 - initial release
// ============================================================================
module ALU #(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3
) (
    input  wire logic [WIDTH-1:0]  a,
    input  wire logic [WIDTH-1:0]  b,
    input  wire logic [OPCODE-1:0] opcode,
    input  wire logic              valid_data,
    output logic      [WIDTH-1:0]  data_out,
    output logic                   carry_out,
    output logic                   zero_flag,
    output logic                   slt_flag,
    output logic                   valid_flag
);

    logic [WIDTH:0] w_sum;
    logic           w_slt;
    logic           w_valid_op;

    always_comb begin
        w_sum      = '0;
        w_valid_op = 1'b1;
        w_slt      = ($signed(a) < $signed(b));
        data_out   = '0;
        carry_out  = 1'b0;
        case (opcode)
            OPCODE'(0): begin
                w_sum     = {1'b0, a} + {1'b0, b};
                data_out  = w_sum[WIDTH-1:0];
                carry_out = w_sum[WIDTH];
            end
            // Carry on subtract is the borrow out.
            OPCODE'(1): begin
                w_sum     = {1'b0, a} - {1'b0, b};
                data_out  = w_sum[WIDTH-1:0];
                carry_out = w_sum[WIDTH];
            end
            OPCODE'(2): data_out = a & b;
            OPCODE'(3): data_out = a | b;
            OPCODE'(4): data_out = a ^ b;
            OPCODE'(5): data_out = {{(WIDTH-1){1'b0}}, w_slt};
            OPCODE'(6): data_out = ~a;
            default:    w_valid_op = 1'b0;
        endcase
        zero_flag  = (data_out == '0);
        slt_flag   = w_slt;
        valid_flag = valid_data & w_valid_op;
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arb
// Purpose  : Two-input round-robin grant; the requester not granted last wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arb
    import alu_arb_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] req_valid,
    input  wire logic               last_grant,
    output logic      [NUM_REQ-1:0] grant,
    output logic                    grant_id
);

    always_comb begin
        grant    = '0;
        grant_id = 1'b0;
        if (&req_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req_valid[1];
        end
        if (|req_valid) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter
// Purpose  : Shares one ALU between two requesters: grant, execute, respond.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OPCODE = DEF_OPCODE
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_req_arbiter_if.slave bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [OPCODE-1:0]  r_op;
    logic               r_id;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_carry;
    logic               r_rsp_zero;
    logic               r_rsp_slt;
    logic               r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_id;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_accept;
    logic               w_alu_valid;
    logic [WIDTH-1:0]   w_alu_data;
    logic               w_alu_carry;
    logic               w_alu_zero;
    logic               w_alu_slt;
    logic               w_alu_vflag;

    alu_rr_arb u_arb (
        .req_valid  (bus.req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    ALU #(
        .WIDTH  (WIDTH),
        .OPCODE (OPCODE)
    ) u_alu (
        .a          (r_a),
        .b          (r_b),
        .opcode     (r_op),
        .valid_data (w_alu_valid),
        .data_out   (w_alu_data),
        .carry_out  (w_alu_carry),
        .zero_flag  (w_alu_zero),
        .slt_flag   (w_alu_slt),
        .valid_flag (w_alu_vflag)
    );

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_alu_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = w_grant;
                if (|(bus.req_valid & w_grant)) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_alu_valid  = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && (|(bus.req_valid & w_grant));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_slt    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a  <= w_grant_id ? bus.req1_a  : bus.req0_a;
                r_b  <= w_grant_id ? bus.req1_b  : bus.req0_b;
                r_op <= w_grant_id ? bus.req1_op : bus.req0_op;
                r_id <= w_grant_id;
            end
            // Priority only moves once the operation has actually executed.
            if (r_state == ST_EXEC) begin
                r_last_grant <= r_id;
                r_rsp_id     <= r_id;
                r_rsp_data   <= w_alu_data;
                r_rsp_carry  <= w_alu_carry;
                r_rsp_zero   <= w_alu_zero;
                r_rsp_slt    <= w_alu_slt;
                r_rsp_err    <= ~w_alu_vflag;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_slt   = r_rsp_slt;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_arbiter
// Purpose  : Directed and random scoreboard bench for alu_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       carry;
        logic       zero;
        logic       slt;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.WIDTH(8), .OPCODE(3)) bus ();

    alu_req_arbiter #(.WIDTH(8), .OPCODE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       scb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_acc = 0;
    int         n_rsp = 0;
    int         waits [2];
    logic       prev_stall = 1'b0;
    exp_t       prev_snap;
    logic [1:0] acc_now = 2'b00;

    function automatic exp_t golden(input logic id, input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] op);
        exp_t e;
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = ua - (a[7] ? 256 : 0);
        int   sb = ub - (b[7] ? 256 : 0);
        e    = '0;
        e.id = id;
        case (op)
            3'd0: begin e.data = 8'(ua + ub); e.carry = (ua + ub) > 255; end
            3'd1: begin e.data = 8'(ua - ub); e.carry = (ua < ub); end
            3'd2: e.data = a & b;
            3'd3: e.data = a | b;
            3'd4: e.data = a ^ b;
            3'd5: e.data = (sa < sb) ? 8'd1 : 8'd0;
            3'd6: e.data = ~a;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.data == 8'd0);
        e.slt  = (sa < sb);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t snap();
        exp_t s;
        s = {bus.rsp_id, bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_slt, bus.rsp_err};
        return s;
    endfunction

    // Called once per cycle at the falling edge: scoreboard push/pop and stall checks.
    task automatic sample();
        exp_t cur;
        exp_t e;
        logic j;
        acc_now = bus.req_valid & bus.req_ready;
        if (!rst_n) begin
            prev_stall = 1'b0;
            return;
        end
        if (acc_now != 2'b00) begin
            check("ready_onehot", 32'($countones(acc_now)), 32'd1);
            j = acc_now[1];
            scb.push_back(j ? golden(1'b1, bus.req1_a, bus.req1_b, bus.req1_op)
                            : golden(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
            n_acc++;
            if (bus.req_valid[~j]) begin
                waits[~j]++;
                check("fair_wait", 32'(waits[~j] <= 1), 32'd1);
            end
            waits[j] = 0;
        end
        cur = snap();
        if (prev_stall && bus.rsp_valid) check("rsp_stable", 32'(cur), 32'(prev_snap));
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (scb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = scb.pop_front();
                check("rsp_fields", 32'(cur), 32'(e));
                n_rsp++;
            end
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_snap  = cur;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        scb.delete();
        waits[0]   = 0;
        waits[1]   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic set_req0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic set_req1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    logic [1:0] pending;
    int         issued;
    int         guard;

    initial begin
        waits[0] = 0;
        waits[1] = 0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        set_req0(8'h00, 8'h00, 3'd0);
        set_req1(8'h00, 8'h00, 3'd0);

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_rsp_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_slt, bus.rsp_err}), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single request from requester 0
        bus.rsp_ready = 1'b1;
        set_req0(8'h0F, 8'h01, 3'd0);
        bus.req_valid = 2'b01;
        #1 check("single_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("single_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("single_exec_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("single_rsp_data",  32'(bus.rsp_data),  32'h10);
        tick();
        check("single_rsp_done", 32'(bus.rsp_valid), 32'd0);

        // Contention right after reset: requester 0 first, then 1
        rst_n = 1'b0;
        #1 flush_model();
        tick();
        rst_n = 1'b1;
        set_req0(8'h80, 8'h7F, 3'd1);
        set_req1(8'h55, 8'hAA, 3'd4);
        bus.req_valid = 2'b11;
        #1 check("cont_first_grant", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 2'b10;
        #1 check("cont_exec_stall", 32'(bus.req_ready), 32'd0);
        tick();
        check("cont_rsp0_valid", 32'(bus.rsp_valid), 32'd1);
        check("cont_rsp0_id",    32'(bus.rsp_id),    32'd0);
        tick();
        check("cont_idle_after_rsp", 32'(bus.rsp_valid), 32'd0);
        check("cont_second_grant",   32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 2'b00;
        tick();
        check("cont_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        check("cont_rsp1_id",    32'(bus.rsp_id),    32'd1);
        tick();

        // Backpressure: response held for 5 cycles while requester 1 waits
        bus.rsp_ready = 1'b0;
        set_req0(8'h33, 8'h33, 3'd1);
        bus.req_valid = 2'b01;
        tick();
        set_req1(8'hFF, 8'h01, 3'd0);
        bus.req_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        check("bp_rsp_zero", 32'(bus.rsp_zero), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_released", 32'(bus.rsp_valid), 32'd0);
        check("bp_idle_grant", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 2'b00;
        tick();
        check("bp_rsp1_carry", 32'(bus.rsp_carry), 32'd1);
        tick();

        // Reset during EXEC: make requester 0 the last grant, then abort its next op
        set_req0(8'h10, 8'h20, 3'd2);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        set_req0(8'h01, 8'h02, 3'd0);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        flush_model();
        check("rstx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstx_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rstx_rsp_id",    32'(bus.rsp_id),    32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rstx_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        set_req0(8'hC0, 8'h40, 3'd5);
        set_req1(8'h07, 8'h07, 3'd7);
        bus.req_valid = 2'b11;
        #1 check("rstx_prio0", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 2'b10;
        tick();
        tick();
        tick();
        bus.req_valid = 2'b00;
        tick();
        check("rstx_err_op", 32'(bus.rsp_err), 32'd1);
        tick();

        // Random regression
        n_acc   = 0;
        n_rsp   = 0;
        pending = 2'b00;
        issued  = 0;
        guard   = 0;
        flush_model();
        while ((issued < 200 || pending != 2'b00 || scb.size() != 0 || bus.rsp_valid) && guard < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && issued < 200 && $urandom_range(0, 1) == 1) begin
                    if (i == 0) set_req0(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
                    else        set_req1(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
                    pending[i] = 1'b1;
                    issued++;
                end
            end
            bus.req_valid = pending;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            pending = pending & ~acc_now;
            guard++;
        end
        check("rand_no_timeout", 32'(guard < 20000), 32'd1);
        check("rand_all_accepted", 32'(n_acc), 32'd200);
        check("rand_rsp_count", 32'(n_rsp), 32'(n_acc));
        check("rand_sb_empty", 32'(scb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
